// File: rtl/mmio_pkg.sv
// mmio_pkg
// Shared types and constants for the AXI-lite MMIO slave that fronts the
// MIPS CPU memory. Holds the FSM state encoding, the address decode result
// type, the AXI response codes and the default control register address.
package mmio_pkg;

    // Transaction FSM states: idle capture, write execute/response,
    // read issue/capture/response.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_EXEC,
        ST_WR_RESP,
        ST_RD_MEM,
        ST_RD_WAIT,
        ST_RD_RESP
    } state_t;

    // Which target an address falls on.
    typedef enum logic [1:0] {
        DEC_MEM,
        DEC_CTRL,
        DEC_ERR
    } decode_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [25:0] DEFAULT_CTRL_ADDR = 26'h0004000;

endpackage

// File: rtl/mmio_axi_lite_slave.sv
// mmio_axi_lite_slave
// AXI-lite slave for the CPU MMIO window. Each AXI-lite write or read turns
// into exactly one single-beat access on a word-addressed synchronous memory
// port (the CPU instruction/data BRAM), and the block also owns the CPU reset
// control register.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   mmio_aw*/mmio_w*/mmio_b*  AXI-lite write address, data and response
//   mmio_ar*/mmio_r*          AXI-lite read address and data/response
//   mem_en/mem_we/mem_addr/   synchronous memory port; read data returns
//   mem_wdata/mem_rdata       one cycle after a read strobe
//   cpu_reset                 active-high CPU reset (control register bit 0)
module mmio_axi_lite_slave
    import mmio_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 26,
    parameter int                    MEM_AW     = 12,
    parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR  = ADDR_WIDTH'(DEFAULT_CTRL_ADDR)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] mmio_awaddr,
    input  logic                  mmio_awvalid,
    output logic                  mmio_awready,
    input  logic [31:0]           mmio_wdata,
    input  logic [3:0]            mmio_wstrb,
    input  logic                  mmio_wvalid,
    output logic                  mmio_wready,
    output logic [1:0]            mmio_bresp,
    output logic                  mmio_bvalid,
    input  logic                  mmio_bready,

    input  logic [ADDR_WIDTH-1:0] mmio_araddr,
    input  logic                  mmio_arvalid,
    output logic                  mmio_arready,
    output logic [31:0]           mmio_rdata,
    output logic [1:0]            mmio_rresp,
    output logic                  mmio_rvalid,
    input  logic                  mmio_rready,

    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,

    output logic                  cpu_reset
);

    state_t              state;
    decode_t             dec_q;
    logic                aw_held;
    logic                w_held;
    logic [MEM_AW-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wstrb_q;
    logic [31:0]         rdata_q;
    logic                cpu_reset_q;

    logic                in_idle;
    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic                unused_addr_bits;

    // Byte-lane bits of the addresses never matter: accesses are whole words.
    assign unused_addr_bits = ^{mmio_awaddr[1:0], mmio_araddr[1:0]};

    // Classifies a word address: the low memory window, the single control
    // word, or nothing (error response).
    function automatic decode_t decode(input logic [ADDR_WIDTH-3:0] word);
        decode_t result;
        result = DEC_ERR;
        if (word[ADDR_WIDTH-3:MEM_AW] == '0) begin
            result = DEC_MEM;
        end else if (word == CTRL_ADDR[ADDR_WIDTH-1:2]) begin
            result = DEC_CTRL;
        end
        return result;
    endfunction

    // Ready signals come straight from the state and held flags. A read is
    // only offered when no write is pending or being presented, so writes
    // win ties and a half-captured write is never interleaved with a read.
    // Everything is held off while reset is asserted.
    assign in_idle      = (state == ST_IDLE) && !rst;
    assign mmio_awready = in_idle && !aw_held;
    assign mmio_wready  = in_idle && !w_held;
    assign mmio_arready = in_idle && !aw_held && !w_held && !mmio_awvalid && !mmio_wvalid;

    assign aw_hs = mmio_awvalid && mmio_awready;
    assign w_hs  = mmio_wvalid  && mmio_wready;
    assign ar_hs = mmio_arvalid && mmio_arready;

    // Memory strobe is a pure function of the execute/issue states, so it is
    // one cycle wide by construction. Gating with rst means a write that
    // coincides with reset never reaches the memory.
    assign mem_en    = !rst && (dec_q == DEC_MEM) &&
                       ((state == ST_WR_EXEC) || (state == ST_RD_MEM));
    assign mem_we    = (!rst && (dec_q == DEC_MEM) && (state == ST_WR_EXEC)) ? wstrb_q : 4'b0000;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Responses are driven from state registers only, never from the
    // master's ready inputs.
    assign mmio_bvalid = !rst && (state == ST_WR_RESP);
    assign mmio_bresp  = (mmio_bvalid && (dec_q == DEC_ERR)) ? RESP_SLVERR : RESP_OKAY;
    assign mmio_rvalid = !rst && (state == ST_RD_RESP);
    assign mmio_rresp  = (mmio_rvalid && (dec_q == DEC_ERR)) ? RESP_SLVERR : RESP_OKAY;
    assign mmio_rdata  = rdata_q;
    assign cpu_reset   = cpu_reset_q;

    // Transaction FSM. In IDLE the write address and write data are captured
    // independently; once both are held the write executes for one cycle and
    // then waits for the B handshake. Reads issue the memory strobe, capture
    // the returned word one cycle later, then hold the R channel until taken.
    // The decode is computed once at capture time and kept in dec_q for the
    // rest of the transaction. Reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            dec_q       <= DEC_ERR;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aw_hs) begin
                        addr_q  <= mmio_awaddr[MEM_AW+1:2];
                        dec_q   <= decode(mmio_awaddr[ADDR_WIDTH-1:2]);
                        aw_held <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q <= mmio_wdata;
                        wstrb_q <= mmio_wstrb;
                        w_held  <= 1'b1;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        state <= ST_WR_EXEC;
                    end else if (ar_hs) begin
                        addr_q <= mmio_araddr[MEM_AW+1:2];
                        dec_q  <= decode(mmio_araddr[ADDR_WIDTH-1:2]);
                        state  <= ST_RD_MEM;
                    end
                end
                ST_WR_EXEC: begin
                    if ((dec_q == DEC_CTRL) && wstrb_q[0]) begin
                        cpu_reset_q <= wdata_q[0];
                    end
                    aw_held <= 1'b0;
                    w_held  <= 1'b0;
                    state   <= ST_WR_RESP;
                end
                ST_WR_RESP: begin
                    if (mmio_bready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RD_MEM: begin
                    state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    case (dec_q)
                        DEC_MEM:  rdata_q <= mem_rdata;
                        DEC_CTRL: rdata_q <= {31'b0, cpu_reset_q};
                        default:  rdata_q <= '0;
                    endcase
                    state <= ST_RD_RESP;
                end
                ST_RD_RESP: begin
                    if (mmio_rready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_axi_lite_slave.sv
// tb_mmio_axi_lite_slave
// Directed bench for the AXI-lite MMIO slave. A behavioural model (word
// array, control bit, expected-response queues) predicts every memory access
// and every B/R response; one compare process checks the DUT on each falling
// edge, and the directed sequence pins the model with literal values.
module tb_mmio_axi_lite_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [25:0] mmio_awaddr = '0;
    logic        mmio_awvalid = 1'b0;
    logic        mmio_awready;
    logic [31:0] mmio_wdata = '0;
    logic [3:0]  mmio_wstrb = '0;
    logic        mmio_wvalid = 1'b0;
    logic        mmio_wready;
    logic [1:0]  mmio_bresp;
    logic        mmio_bvalid;
    logic        mmio_bready = 1'b1;
    logic [25:0] mmio_araddr = '0;
    logic        mmio_arvalid = 1'b0;
    logic        mmio_arready;
    logic [31:0] mmio_rdata;
    logic [1:0]  mmio_rresp;
    logic        mmio_rvalid;
    logic        mmio_rready = 1'b0;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        cpu_reset;

    always #5 clk = ~clk;

    mmio_axi_lite_slave dut (
        .clk          (clk),
        .rst          (rst),
        .mmio_awaddr  (mmio_awaddr),
        .mmio_awvalid (mmio_awvalid),
        .mmio_awready (mmio_awready),
        .mmio_wdata   (mmio_wdata),
        .mmio_wstrb   (mmio_wstrb),
        .mmio_wvalid  (mmio_wvalid),
        .mmio_wready  (mmio_wready),
        .mmio_bresp   (mmio_bresp),
        .mmio_bvalid  (mmio_bvalid),
        .mmio_bready  (mmio_bready),
        .mmio_araddr  (mmio_araddr),
        .mmio_arvalid (mmio_arvalid),
        .mmio_arready (mmio_arready),
        .mmio_rdata   (mmio_rdata),
        .mmio_rresp   (mmio_rresp),
        .mmio_rvalid  (mmio_rvalid),
        .mmio_rready  (mmio_rready),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .cpu_reset    (cpu_reset)
    );

    // Synchronous BRAM behind the memory port: byte-enabled writes, read
    // data one cycle after a read strobe.
    logic [31:0] bram [0:4095];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_rdata <= bram[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    typedef struct packed {
        logic [11:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
    } mem_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic [31:0] ref_mem [0:4095];
    logic        model_ctrl = 1'b1;
    mem_exp_t    mem_q [$];
    logic [1:0]  b_q [$];
    r_exp_t      r_q [$];
    bit          busy = 1'b0;

    int          total = 0;
    int          passed = 0;

    logic [31:0] last_rdata;
    logic [1:0]  last_rresp;
    logic [1:0]  last_bresp;
    logic [11:0] wr_mem_addr;
    logic [3:0]  wr_mem_we;
    logic        cr_at_exec;
    logic        cr_at_resp;
    time         b_done_time;
    time         ar_time;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // 0 = memory window (first 16 KB), 1 = control word at 0x4000, 2 = error.
    function automatic int region(input logic [25:0] a);
        if (a < 26'h0004000) return 0;
        if ((a >> 2) == (26'h0004000 >> 2)) return 1;
        return 2;
    endfunction

    task automatic modelWrite(input logic [25:0] a, input logic [31:0] d, input logic [3:0] s);
        int r;
        mem_exp_t e;
        r = region(a);
        if (r == 0) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) ref_mem[a[13:2]][8*b +: 8] = d[8*b +: 8];
            end
            e.addr = a[13:2];
            e.we   = s;
            e.data = d;
            mem_q.push_back(e);
        end else if (r == 1 && s[0]) begin
            model_ctrl = d[0];
        end
        b_q.push_back((r == 2) ? 2'b10 : 2'b00);
    endtask

    task automatic modelRead(input logic [25:0] a);
        int r;
        mem_exp_t e;
        r_exp_t x;
        r = region(a);
        if (r == 0) begin
            e.addr = a[13:2];
            e.we   = 4'b0000;
            e.data = '0;
            mem_q.push_back(e);
            x.data = ref_mem[a[13:2]];
        end else if (r == 1) begin
            x.data = {31'b0, model_ctrl};
        end else begin
            x.data = '0;
        end
        x.resp = (r == 2) ? 2'b10 : 2'b00;
        r_q.push_back(x);
    endtask

    task automatic clearModel();
        mem_q.delete();
        b_q.delete();
        r_q.delete();
        busy       = 1'b0;
        model_ctrl = 1'b1;
    endtask

    // Presents AW and W, each starting after its own delay and dropped once
    // accepted, then measures the latency to mem_en and bvalid.
    task automatic writeTxn(input logic [25:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_delay, input int w_delay);
        bit   aw_done = 0;
        bit   w_done = 0;
        bit   hs_aw;
        bit   hs_w;
        int   c = 0;
        int   lat = 0;
        logic exp_mem;
        exp_mem     = (region(a) == 0);
        mmio_awaddr = a;
        mmio_wdata  = d;
        mmio_wstrb  = s;
        while (!(aw_done && w_done) && c < 40) begin
            mmio_awvalid = !aw_done && (c >= aw_delay);
            mmio_wvalid  = !w_done && (c >= w_delay);
            @(negedge clk);
            if (w_done && !aw_done) begin
                checkOutput("w_held_wready", 32'(mmio_wready), 32'd0);
                checkOutput("w_held_arready", 32'(mmio_arready), 32'd0);
            end
            hs_aw = mmio_awvalid && mmio_awready;
            hs_w  = mmio_wvalid && mmio_wready;
            @(posedge clk);
            #1;
            if (hs_aw) aw_done = 1;
            if (hs_w) w_done = 1;
            c++;
        end
        mmio_awvalid = 1'b0;
        mmio_wvalid  = 1'b0;
        checkOutput("wr_accepted", 32'(aw_done && w_done), 32'd1);
        if (!(aw_done && w_done)) return;
        modelWrite(a, d, s);
        busy = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                checkOutput("wr_mem_en", 32'(mem_en), 32'(exp_mem));
                wr_mem_addr = mem_addr;
                wr_mem_we   = mem_we;
                cr_at_exec  = cpu_reset;
            end
        end while (!mmio_bvalid && lat < 20);
        checkOutput("wr_latency", 32'(lat), 32'd2);
        cr_at_resp = cpu_reset;
        last_bresp = mmio_bresp;
        @(posedge clk);
        #1;
        busy        = 1'b0;
        b_done_time = $time;
    endtask

    // Presents AR until accepted, measures latency to rvalid, then either
    // stalls rready for rready_hold cycles or returns with rvalid still up.
    task automatic readTxn(input logic [25:0] a, input int rready_hold, input bit abort);
        bit   done = 0;
        int   c = 0;
        int   lat = 0;
        logic exp_mem;
        exp_mem      = (region(a) == 0);
        mmio_araddr  = a;
        mmio_arvalid = 1'b1;
        while (!done && c < 60) begin
            @(negedge clk);
            done = mmio_arready;
            @(posedge clk);
            #1;
            c++;
        end
        mmio_arvalid = 1'b0;
        checkOutput("rd_accepted", 32'(done), 32'd1);
        if (!done) return;
        ar_time = $time;
        modelRead(a);
        busy = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) checkOutput("rd_mem_en", 32'(mem_en), 32'(exp_mem));
        end while (!mmio_rvalid && lat < 20);
        checkOutput("rd_latency", 32'(lat), 32'd3);
        last_rdata = mmio_rdata;
        last_rresp = mmio_rresp;
        if (abort) return;
        repeat (rready_hold + 1) @(posedge clk);
        #1;
        mmio_rready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        mmio_rready = 1'b0;
        busy        = 1'b0;
    endtask

    task automatic applyStimulus(input bit is_write, input logic [25:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input int aw_delay, input int w_delay,
                                 input int rready_hold, input bit abort);
        if (is_write) writeTxn(a, d, s, aw_delay, w_delay);
        else readTxn(a, rready_hold, abort);
    endtask

    // Per-cycle comparison against the model: reset outputs, every memory
    // access in order, readys held off while a transaction is in flight,
    // the control bit, B/R responses, and R-channel stability under stall.
    bit          prev_mem_en = 0;
    bit          r_stall = 0;
    logic [31:0] r_prev = '0;
    always @(negedge clk) begin
        mem_exp_t e;
        if (rst) begin
            checkOutput("rst_outputs",
                        32'({mmio_awready, mmio_wready, mmio_arready, mmio_bvalid, mmio_rvalid,
                             mem_en, mem_we, mmio_bresp, mmio_rresp}), 32'd0);
            prev_mem_en = 0;
            r_stall     = 0;
        end else begin
            if (mem_en) begin
                checkOutput("mem_en_gap", 32'(prev_mem_en), 32'd0);
                checkOutput("mem_expected", 32'(mem_q.size() != 0), 32'd1);
                if (mem_q.size() != 0) begin
                    e = mem_q.pop_front();
                    checkOutput("mem_addr", 32'(mem_addr), 32'(e.addr));
                    checkOutput("mem_we", 32'(mem_we), 32'(e.we));
                    if (e.we != 4'b0000) checkOutput("mem_wdata", mem_wdata, e.data);
                end
            end
            if (busy) begin
                checkOutput("busy_awready", 32'(mmio_awready), 32'd0);
                checkOutput("busy_wready", 32'(mmio_wready), 32'd0);
                checkOutput("busy_arready", 32'(mmio_arready), 32'd0);
            end else begin
                checkOutput("cpu_reset", 32'(cpu_reset), 32'(model_ctrl));
            end
            if (mmio_bvalid) begin
                checkOutput("b_expected", 32'(b_q.size() != 0), 32'd1);
                if (b_q.size() != 0) begin
                    checkOutput("bresp", 32'(mmio_bresp), 32'(b_q[0]));
                    checkOutput("b_cpu_reset", 32'(cpu_reset), 32'(model_ctrl));
                    if (mmio_bready) void'(b_q.pop_front());
                end
            end
            if (r_stall) begin
                checkOutput("r_hold_valid", 32'(mmio_rvalid), 32'd1);
                checkOutput("r_hold_data", mmio_rdata, r_prev);
            end
            if (mmio_rvalid) begin
                checkOutput("r_expected", 32'(r_q.size() != 0), 32'd1);
                if (r_q.size() != 0) begin
                    checkOutput("rdata", mmio_rdata, r_q[0].data);
                    checkOutput("rresp", 32'(mmio_rresp), 32'(r_q[0].resp));
                    if (mmio_rready) void'(r_q.pop_front());
                end
            end
            prev_mem_en = mem_en;
            r_stall     = mmio_rvalid && !mmio_rready;
            r_prev      = mmio_rdata;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation reached %0t without finishing, required under 200000", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        clearModel();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("reset_rdata", mmio_rdata, 32'd0);
        checkOutput("idle_awready", 32'(mmio_awready), 32'd1);
        checkOutput("idle_arready", 32'(mmio_arready), 32'd1);
        @(posedge clk);
        #1;

        // Aligned write of 0xDEADBEEF to 0x10.
        applyStimulus(1, 26'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
        checkOutput("aligned_mem_addr", 32'(wr_mem_addr), 32'd4);
        checkOutput("aligned_mem_we", 32'(wr_mem_we), 32'hF);
        checkOutput("aligned_bresp", 32'(last_bresp), 32'd0);

        // Full-word preload, then W three cycles ahead of AW with a partial strobe.
        applyStimulus(1, 26'h24, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 0);
        applyStimulus(1, 26'h24, 32'h12345678, 4'h5, 3, 0, 0, 0);
        checkOutput("wfirst_mem_addr", 32'(wr_mem_addr), 32'd9);
        checkOutput("wfirst_mem_we", 32'(wr_mem_we), 32'h5);

        // Read back with rready stalled for five cycles.
        applyStimulus(0, 26'h10, 32'h0, 4'h0, 0, 0, 5, 0);
        checkOutput("readback_rdata", last_rdata, 32'hDEADBEEF);
        checkOutput("readback_rresp", 32'(last_rresp), 32'd0);
        applyStimulus(0, 26'h24, 32'h0, 4'h0, 0, 0, 0, 0);
        checkOutput("partial_rdata", last_rdata, 32'hA534A578);

        // Error address: SLVERR on both channels, no memory access, zero data.
        applyStimulus(1, 26'h3FFFFFC, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0);
        checkOutput("err_bresp", 32'(last_bresp), 32'd2);
        applyStimulus(0, 26'h3FFFFFC, 32'h0, 4'h0, 0, 0, 1, 0);
        checkOutput("err_rdata", last_rdata, 32'd0);
        checkOutput("err_rresp", 32'(last_rresp), 32'd2);

        // Control register: release CPU reset, then read it back.
        applyStimulus(1, 26'h4000, 32'h0, 4'hF, 0, 0, 0, 0);
        checkOutput("ctrl_at_exec", 32'(cr_at_exec), 32'd1);
        checkOutput("ctrl_at_resp", 32'(cr_at_resp), 32'd0);
        checkOutput("ctrl_bresp", 32'(last_bresp), 32'd0);
        applyStimulus(0, 26'h4000, 32'h0, 4'h0, 0, 0, 0, 0);
        checkOutput("ctrl_rdata", last_rdata, 32'd0);
        checkOutput("ctrl_rresp", 32'(last_rresp), 32'd0);

        // AR, AW and W all presented together: the write goes first.
        fork
            applyStimulus(1, 26'h30, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
            applyStimulus(0, 26'h30, 32'h0, 4'h0, 0, 0, 0, 0);
        join
        checkOutput("tie_order", 32'(ar_time > b_done_time), 32'd1);
        checkOutput("tie_rdata", last_rdata, 32'hCAFEF00D);

        // Reset while the read response is waiting.
        applyStimulus(0, 26'h10, 32'h0, 4'h0, 0, 0, 0, 1);
        #1;
        rst         = 1'b1;
        mmio_rready = 1'b0;
        clearModel();
        @(posedge clk);
        #1;
        checkOutput("abort_rvalid", 32'(mmio_rvalid), 32'd0);
        checkOutput("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("abort_rdata", mmio_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_rvalid", 32'(mmio_rvalid), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(0, 26'h10, 32'h0, 4'h0, 0, 0, 0, 0);
        checkOutput("post_reset_rdata", last_rdata, 32'hDEADBEEF);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("mem_q_drained", 32'(mem_q.size()), 32'd0);
        checkOutput("b_q_drained", 32'(b_q.size()), 32'd0);
        checkOutput("r_q_drained", 32'(r_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
